uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
- REQ-001: The module SHALL have parameter PulsePerBit, default 434, meaning clk cycles per UART bit (clk frequency / baud); the legal range SHALL be 4..511.
- REQ-002: The module SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
- REQ-003: The module SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
- REQ-004: The module SHALL have port i_Rx_Serial, input, 1 bit: asynchronous serial line, idle high.
- REQ-005: The module SHALL have port o_DV, output, 1 bit: one-cycle pulse when a valid byte is on o_Rx_Byte.
- REQ-006: The module SHALL have port o_Rx_Byte, output, 8 bits: last correctly received byte.
- REQ-007: The module SHALL have port o_Frame_Err, output, 1 bit: one-cycle pulse on a stop-bit error.
- REQ-008: The module SHALL have port o_Rx_Busy, output, 1 bit: high whenever the state is not IDLE.

Function
- REQ-009: i_Rx_Serial SHALL pass through a 2-flop synchronizer (both flops reset to 1); all decisions SHALL use the synchronized value (rx_s).
- REQ-010: The frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- REQ-011: The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_HIGH, using one 9-bit cycle counter and one 3-bit bit index.
- REQ-012: IDLE SHALL clear the counter and index, and SHALL go to START in the cycle after rx_s is sampled 0.
- REQ-013: START SHALL count up to (PulsePerBit-1)/2 (integer division), which is mid start bit.
  - If rx_s is 0 there: clear the counter and go to DATA.
  - If rx_s is 1 there: glitch; go to IDLE with no output pulse.
- REQ-014: DATA SHALL count to PulsePerBit-1, then shift rx_s into data bit [index] and clear the counter.
  - Index 0..6: increment the index.
  - Index 7: clear the index and go to STOP.
- REQ-015: STOP SHALL count to PulsePerBit-1, then sample rx_s.
  - rx_s = 1: load o_Rx_Byte from the shift register, pulse o_DV for exactly one cycle, go to IDLE.
  - rx_s = 0: pulse o_Frame_Err for one cycle, leave o_Rx_Byte unchanged, no o_DV, go to WAIT_HIGH.
- REQ-016: WAIT_HIGH SHALL hold until rx_s is 1, then go to IDLE, so that a break or stuck-low line never starts a new frame.
- REQ-017: o_DV and o_Frame_Err SHALL be registered, SHALL never be high in the same cycle, and SHALL each be high for at most one cycle per frame.
- REQ-018: o_Rx_Byte SHALL change only in the cycle o_DV rises, and SHALL otherwise hold its value indefinitely.
- REQ-019: o_DV SHALL assert 2 + 1 + (PulsePerBit-1)/2 + 9*PulsePerBit + 1 clk cycles (±1) after the falling start edge at i_Rx_Serial.
- REQ-020: Because return to IDLE occurs at mid stop bit, a start bit immediately following a stop bit (back-to-back frames) SHALL be received without loss.
- REQ-021: i_Rx_Serial toggling during START/DATA/STOP outside the sample points SHALL have no effect; only the single mid-bit sample per bit counts.
- REQ-022: The counter SHALL never exceed PulsePerBit-1; unreachable state encodings SHALL return to IDLE next cycle.

Reset
- REQ-023: rst_n low SHALL immediately force, regardless of clk:
  - state IDLE, counter 0, index 0, shift register 0x00;
  - o_Rx_Byte 0x00, o_DV 0, o_Frame_Err 0, o_Rx_Busy 0;
  - synchronizer flops 1.
- REQ-024: Reset asserted mid-frame SHALL discard the partial byte with no pulse.
- REQ-025: After rst_n deasserts, the first frame whose start edge occurs at least 2 cycles later SHALL be received normally.

Verification (PulsePerBit=16 unless stated)
- REQ-026: Send 0xA5 -> exactly one o_DV pulse, o_Rx_Byte=0xA5, o_Frame_Err never high, o_Rx_Busy low afterward.
- REQ-027: Drive i_Rx_Serial low for 3 cycles, then high -> o_Rx_Busy pulses, state returns to IDLE, no o_DV, no o_Frame_Err, o_Rx_Byte unchanged.
- REQ-028: Send 0x3C with stop bit 0, hold the line low 100 cycles, release, send 0x0F:
  - first frame -> one o_Frame_Err pulse, no o_DV, o_Rx_Byte stays 0xA5;
  - no frame starts during the low hold;
  - 0x0F frame -> o_DV with o_Rx_Byte=0x0F.
- REQ-029: Send back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three o_DV pulses with bytes in that order, no errors.
- REQ-030: Assert rst_n low during data bit 4 of 0x81 -> all outputs 0 immediately; release, then send 0x81 -> o_DV, o_Rx_Byte=0x81.
- REQ-031: With PulsePerBit=32, drive a transmitter bit period of 31 cycles and then 33 cycles, sending 0xC3 each time -> both frames received as 0xC3 with o_DV.

Source files
------------

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits, LSB first, one stop bit, no parity.
// The serial line is synchronised, the start bit is confirmed at its midpoint,
// and every further bit is sampled once, a full bit period after the previous
// sample. A low stop bit reports a framing error. The receiver then waits for
// the line to return high before it will look for another start bit.
module uart_rx #(
    parameter int PulsePerBit = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_Rx_Serial,
    output logic       o_DV,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Frame_Err,
    output logic       o_Rx_Busy
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } state_e;

    // Last counter value of a full bit period, and the midpoint of the start bit.
    localparam logic [8:0] CNT_BIT_LAST = 9'(PulsePerBit - 1);
    localparam logic [8:0] CNT_HALF     = 9'((PulsePerBit - 1) / 2);

    logic       rx_meta_q;
    logic       rx_sync_q;
    logic       rx_s;

    state_e     state_q;
    state_e     state_d;
    logic [8:0] cnt_q;
    logic [8:0] cnt_d;
    logic [2:0] idx_q;
    logic [2:0] idx_d;
    logic [7:0] shift_q;
    logic [7:0] shift_d;
    logic [7:0] byte_q;
    logic [7:0] byte_d;
    logic       dv_q;
    logic       dv_d;
    logic       ferr_q;
    logic       ferr_d;
    logic       busy_q;
    logic       busy_d;

    assign rx_s        = rx_sync_q;
    assign o_DV        = dv_q;
    assign o_Rx_Byte   = byte_q;
    assign o_Frame_Err = ferr_q;
    assign o_Rx_Busy   = busy_q;

    // Two-flop synchroniser for the asynchronous line. Both flops reset to the idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= i_Rx_Serial;
            rx_sync_q <= rx_meta_q;
        end
    end

    // State, counter, shift register and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= 9'd0;
            idx_q   <= 3'd0;
            shift_q <= 8'h00;
            byte_q  <= 8'h00;
            dv_q    <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
            ferr_q  <= ferr_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state logic. Each bit is sampled exactly once at its midpoint, and the pulses last one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        dv_d    = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 9'd0;
                idx_d = 3'd0;
                if (!rx_s) begin
                    state_d = ST_START;
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_START: begin
                if (cnt_q >= CNT_HALF) begin
                    cnt_d = 9'd0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                    end else begin
                        // The line went high again before mid-bit, so this was a glitch and not a start bit.
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end

            ST_DATA: begin
                if (cnt_q >= CNT_BIT_LAST) begin
                    cnt_d          = 9'd0;
                    shift_d[idx_q] = rx_s;
                    if (idx_q == 3'd7) begin
                        idx_d   = 3'd0;
                        state_d = ST_STOP;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end

            ST_STOP: begin
                if (cnt_q >= CNT_BIT_LAST) begin
                    cnt_d = 9'd0;
                    if (rx_s) begin
                        // Return to idle at mid stop bit, so a start bit that follows immediately is still caught.
                        byte_d  = shift_q;
                        dv_d    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 9'd1;
                end
            end

            ST_WAIT_HIGH: begin
                cnt_d = 9'd0;
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    // A break or a stuck-low line is held off here so that it cannot start a new frame.
                    state_d = ST_WAIT_HIGH;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = 9'd0;
                idx_d   = 3'd0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed and randomised frames are checked against an
// expected-byte queue and the frame timing worked out from the bit period.
module tb_uart_rx;

    localparam int P   = 16;
    localparam int P2  = 32;
    localparam int H   = (P - 1) / 2;
    localparam int LAT = 2 + 1 + H + 9 * P + 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx16  = 1'b1;
    logic       rx32  = 1'b1;
    logic       dv16, ferr16, busy16;
    logic [7:0] byte16;
    logic       dv32, ferr32, busy32;
    logic [7:0] byte32;

    always #5 clk = ~clk;

    uart_rx #(.PulsePerBit(P)) dut (
        .clk(clk), .rst_n(rst_n), .i_Rx_Serial(rx16),
        .o_DV(dv16), .o_Rx_Byte(byte16), .o_Frame_Err(ferr16), .o_Rx_Busy(busy16)
    );

    uart_rx #(.PulsePerBit(P2)) dut32 (
        .clk(clk), .rst_n(rst_n), .i_Rx_Serial(rx32),
        .o_DV(dv32), .o_Rx_Byte(byte32), .o_Frame_Err(ferr32), .o_Rx_Busy(busy32)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: records received bytes and counts any misbehaving pulses.
    logic [7:0] got_q[$];
    logic [7:0] got32_q[$];
    int dv_cnt = 0, ferr_cnt = 0, overlap_cnt = 0, long_cnt = 0, byte_bad_cnt = 0, busy_cnt = 0;
    int last_dv_cyc = 0, ferr32_cnt = 0;
    logic prev_dv = 1'b0, prev_ferr = 1'b0;
    logic [7:0] prev_byte = 8'h00;

    always @(negedge clk) begin
        if (rst_n) begin
            if (dv16) begin
                got_q.push_back(byte16);
                dv_cnt++;
                last_dv_cyc = cyc;
            end
            if (ferr16) ferr_cnt++;
            if (dv16 && ferr16) overlap_cnt++;
            if ((dv16 && prev_dv) || (ferr16 && prev_ferr)) long_cnt++;
            if ((byte16 !== prev_byte) && !dv16) byte_bad_cnt++;
            if (busy16) busy_cnt++;
            if (dv32) got32_q.push_back(byte32);
            if (ferr32) ferr32_cnt++;
        end
        prev_dv   = dv16;
        prev_ferr = ferr16;
        prev_byte = byte16;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_byte(input string tag, input logic [7:0] exp);
        logic [7:0] got;
        if (got_q.size() > 0) begin
            got = got_q.pop_front();
        end else begin
            got = 8'hxx;
        end
        check(tag, {24'd0, got}, {24'd0, exp});
    endtask

    task automatic drive(input int which, input logic v);
        if (which == 0) rx16 = v;
        else rx32 = v;
    endtask

    // Sends one frame from a negedge. With glitch set, each data bit is inverted for one cycle early in the bit.
    task automatic send_frame(input int which, input logic [7:0] b, input logic stop,
                              input int per, input bit glitch);
        drive(which, 1'b0);
        if (which == 0) start_cyc = cyc;
        repeat (per) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            drive(which, b[i]);
            if (glitch) begin
                repeat (2) @(negedge clk);
                drive(which, ~b[i]);
                @(negedge clk);
                drive(which, b[i]);
                repeat (per - 3) @(negedge clk);
            end else begin
                repeat (per) @(negedge clk);
            end
        end
        drive(which, stop);
        repeat (per) @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, f0, b0, lat, nbad, gap, hold;
        logic [7:0] rb, last_good;
        logic good;
        bit gl;
        logic [7:0] exp_q[$];

        // Outputs held in reset.
        repeat (3) @(negedge clk);
        check("rst_dv", {31'd0, dv16}, 32'd0);
        check("rst_byte", {24'd0, byte16}, 32'd0);
        check("rst_ferr", {31'd0, ferr16}, 32'd0);
        check("rst_busy", {31'd0, busy16}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // A single good frame, 0xA5.
        d0 = dv_cnt; f0 = ferr_cnt;
        send_frame(0, 8'hA5, 1'b1, P, 1'b0);
        repeat (10) @(negedge clk);
        check("a5_dv_count", dv_cnt - d0, 32'd1);
        check("a5_ferr_count", ferr_cnt - f0, 32'd0);
        expect_byte("a5_byte", 8'hA5);
        check("a5_out_byte", {24'd0, byte16}, 32'hA5);
        check("a5_busy_after", {31'd0, busy16}, 32'd0);
        lat = last_dv_cyc - start_cyc;
        checks++;
        assert (lat >= LAT - 1 && lat <= LAT + 1) else begin
            errors++;
            $error("FAIL dv_latency observed=%0d expected=%0d..%0d", lat, LAT - 1, LAT + 1);
        end

        // A 3-cycle low glitch is rejected.
        d0 = dv_cnt; f0 = ferr_cnt; b0 = busy_cnt;
        rx16 = 1'b0;
        repeat (3) @(negedge clk);
        rx16 = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_busy_seen", 32'(busy_cnt > b0), 32'd1);
        check("glitch_busy_low", {31'd0, busy16}, 32'd0);
        check("glitch_no_dv", dv_cnt - d0, 32'd0);
        check("glitch_no_ferr", ferr_cnt - f0, 32'd0);
        check("glitch_byte", {24'd0, byte16}, 32'hA5);

        // A bad stop bit followed by a long low hold, then a good frame.
        d0 = dv_cnt; f0 = ferr_cnt;
        send_frame(0, 8'h3C, 1'b0, P, 1'b0);
        repeat (100) @(negedge clk);
        check("ferr_count", ferr_cnt - f0, 32'd1);
        check("ferr_no_dv", dv_cnt - d0, 32'd0);
        check("ferr_byte_kept", {24'd0, byte16}, 32'hA5);
        check("hold_busy", {31'd0, busy16}, 32'd1);
        rx16 = 1'b1;
        repeat (200) @(negedge clk);
        check("hold_no_frame_dv", dv_cnt - d0, 32'd0);
        check("hold_no_frame_ferr", ferr_cnt - f0, 32'd1);
        check("release_busy", {31'd0, busy16}, 32'd0);
        send_frame(0, 8'h0F, 1'b1, P, 1'b0);
        repeat (10) @(negedge clk);
        expect_byte("after_ferr_byte", 8'h0F);
        check("after_ferr_out", {24'd0, byte16}, 32'h0F);

        // Back-to-back frames with no idle gap between them, data bits glitched between sample points.
        d0 = dv_cnt; f0 = ferr_cnt;
        send_frame(0, 8'h00, 1'b1, P, 1'b1);
        send_frame(0, 8'hFF, 1'b1, P, 1'b1);
        send_frame(0, 8'h55, 1'b1, P, 1'b1);
        repeat (10) @(negedge clk);
        check("b2b_dv_count", dv_cnt - d0, 32'd3);
        check("b2b_ferr", ferr_cnt - f0, 32'd0);
        expect_byte("b2b_0", 8'h00);
        expect_byte("b2b_1", 8'hFF);
        expect_byte("b2b_2", 8'h55);

        // Reset asserted during data bit 4 of 0x81.
        d0 = dv_cnt; f0 = ferr_cnt;
        rx16 = 1'b0;
        repeat (P) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rb = 8'h81;
            rx16 = rb[i];
            repeat (P) @(negedge clk);
        end
        rx16 = 1'b0;
        repeat (P / 2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dv", {31'd0, dv16}, 32'd0);
        check("midrst_byte", {24'd0, byte16}, 32'd0);
        check("midrst_ferr", {31'd0, ferr16}, 32'd0);
        check("midrst_busy", {31'd0, busy16}, 32'd0);
        rx16 = 1'b1;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(0, 8'h81, 1'b1, P, 1'b0);
        repeat (10) @(negedge clk);
        check("midrst_dv_count", dv_cnt - d0, 32'd1);
        check("midrst_ferr_count", ferr_cnt - f0, 32'd0);
        expect_byte("post_rst_byte", 8'h81);

        // Random frames, some with a bad stop bit, compared against the expected-byte queue.
        d0 = dv_cnt; f0 = ferr_cnt; nbad = 0; last_good = 8'h81;
        for (int k = 0; k < 10; k++) begin
            rb   = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            gl   = 1'($urandom_range(0, 1));
            gap  = $urandom_range(0, 12);
            send_frame(0, rb, good, P, gl);
            if (good) begin
                exp_q.push_back(rb);
                last_good = rb;
            end else begin
                nbad++;
                hold = $urandom_range(20, 60);
                repeat (hold) @(negedge clk);
                rx16 = 1'b1;
                repeat (30) @(negedge clk);
            end
            repeat (gap) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("rand_dv_count", dv_cnt - d0, 32'(exp_q.size()));
        check("rand_ferr_count", ferr_cnt - f0, 32'(nbad));
        while (exp_q.size() > 0) begin
            expect_byte("rand_byte", exp_q.pop_front());
        end
        check("rand_last_byte", {24'd0, byte16}, {24'd0, last_good});

        // Transmitter bit periods of 31 and 33 cycles on the 32-cycle receiver.
        send_frame(1, 8'hC3, 1'b1, 31, 1'b0);
        repeat (10) @(negedge clk);
        send_frame(1, 8'hC3, 1'b1, 33, 1'b0);
        repeat (10) @(negedge clk);
        check("p32_count", 32'(got32_q.size()), 32'd2);
        check("p32_ferr", 32'(ferr32_cnt), 32'd0);
        for (int i = 0; i < 2; i++) begin
            if (got32_q.size() > 0) rb = got32_q.pop_front();
            else rb = 8'hxx;
            check("p32_byte", {24'd0, rb}, 32'hC3);
        end

        // Pulse properties over the whole run.
        check("dv_ferr_overlap", 32'(overlap_cnt), 32'd0);
        check("pulse_too_long", 32'(long_cnt), 32'd0);
        check("byte_changed_without_dv", 32'(byte_bad_cnt), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
